// File: rtl/edge_detect_3x3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : edge_pkg
// Description : Shared types and constants for the 3x3 edge detector.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package edge_pkg;

  // Kernel selection: the side taps of the gradient kernel weigh 2 (Sobel) or 1 (Prewitt)
  typedef enum logic {
    KERNEL_SOBEL   = 1'b0,
    KERNEL_PREWITT = 1'b1
  } kernel_e;

  // Cycles from an input pixel sample to its output
  localparam int PIPE_LAT = 4;

  // Width helpers at the default pixel width
  localparam int DEF_DATA_WIDTH = 8;
  localparam int GRAD_W         = DEF_DATA_WIDTH + 2;
  localparam int SUM_W          = DEF_DATA_WIDTH + 3;

  // Width of one absolute gradient for a given pixel width
  function automatic int grad_w(input int dw);
    return dw + 2;
  endfunction

  // Width of |Gx|+|Gy| for a given pixel width
  function automatic int sum_w(input int dw);
    return dw + 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_detect_3x3_window.sv
`default_nettype none
// ============================================================================
// Module      : window_3x3
// Description : Two-line buffer, 3x3 register window, column/row counters,
//               border mask, frame-start detection and line-length error.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module window_3x3 import edge_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                       clk,
  input  logic                       reset_p,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  input  logic                       in_hsync,
  input  logic                       in_vsync,
  output logic                       frame_start,
  output logic [8:0][DATA_WIDTH-1:0] win,
  output logic                       win_mask,
  output logic                       line_len_err
);

  localparam int                   c_addr_w  = $clog2(IMG_WIDTH);
  localparam logic [CNT_WIDTH-1:0] c_col_max = CNT_WIDTH'(IMG_WIDTH);
  localparam logic [CNT_WIDTH-1:0] c_row_max = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] c_two     = CNT_WIDTH'(2);

  logic                       r_vsync_d;
  logic                       r_hsync_d;
  logic                       r_armed;
  logic                       r_frame_ok;
  logic [CNT_WIDTH-1:0]       r_col;
  logic [CNT_WIDTH-1:0]       r_row;
  logic [8:0][DATA_WIDTH-1:0] r_win;
  logic                       r_mask;
  logic                       r_len_err;
  logic [DATA_WIDTH-1:0]      r_lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0]      r_lb2 [IMG_WIDTH];

  logic                       w_rise;
  logic                       w_active;
  logic                       w_line_px;
  logic                       w_col_full;
  logic                       w_shift;
  logic [c_addr_w-1:0]        w_addr;
  logic [DATA_WIDTH-1:0]      w_top;
  logic [DATA_WIDTH-1:0]      w_mid;

  // A rise only counts once vsync has been seen low since reset, so a reset
  // in the middle of a frame keeps everything masked until the next frame.
  assign w_rise     = in_vsync & ~r_vsync_d & r_armed;
  assign w_active   = in_vsync & (r_frame_ok | w_rise);
  assign w_line_px  = in_valid & in_hsync & w_active;
  assign w_col_full = (r_col == c_col_max);
  assign w_shift    = w_line_px & ~w_col_full;
  assign w_addr     = r_col[c_addr_w-1:0];
  assign w_top      = r_lb2[w_addr];
  assign w_mid      = r_lb1[w_addr];

  assign frame_start  = w_rise;
  assign win          = r_win;
  assign win_mask     = r_mask;
  assign line_len_err = r_len_err;

  // Sync history and frame-valid tracking
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_vsync_d  <= 1'b0;
      r_hsync_d  <= 1'b0;
      r_armed    <= 1'b0;
      r_frame_ok <= 1'b0;
    end else begin
      r_vsync_d  <= in_vsync;
      r_hsync_d  <= in_hsync;
      r_armed    <= r_armed | ~in_vsync;
      r_frame_ok <= w_active;
    end
  end

  // Column counts accepted pixels in the line, row counts completed lines
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_col <= '0;
      r_row <= '0;
    end else begin
      if (!in_hsync || !w_active) begin
        r_col <= '0;
      end else if (w_shift) begin
        r_col <= r_col + 1'b1;
      end
      if (!w_active) begin
        r_row <= '0;
      end else if (r_hsync_d && !in_hsync && (r_row != c_row_max)) begin
        r_row <= r_row + 1'b1;
      end
    end
  end

  // Sticky overlength flag: a pixel arrived with the line already full
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_len_err <= 1'b0;
    end else if (w_line_px && w_col_full) begin
      r_len_err <= 1'b1;
    end
  end

  // 3x3 window, column 2 is the newest pixel; cleared outside active lines
  always_ff @(posedge clk) begin
    if (reset_p || !in_hsync || !in_vsync) begin
      r_win <= '0;
    end else if (w_shift) begin
      r_win[0] <= r_win[1];
      r_win[1] <= r_win[2];
      r_win[2] <= w_top;
      r_win[3] <= r_win[4];
      r_win[4] <= r_win[5];
      r_win[5] <= w_mid;
      r_win[6] <= r_win[7];
      r_win[7] <= r_win[8];
      r_win[8] <= in_data;
    end
  end

  // Border mask travels with the pixel that captured the window
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_mask <= 1'b0;
    end else if (in_valid) begin
      r_mask <= w_shift && (r_col >= c_two) && (r_row >= c_two);
    end
  end

  // Line buffers are not reset; stale content is hidden by the mask
  always_ff @(posedge clk) begin
    if (w_shift) begin
      r_lb1[w_addr] <= in_data;
      r_lb2[w_addr] <= w_mid;
    end
  end

endmodule
`default_nettype wire

// File: rtl/edge_detect_3x3.sv
`default_nettype none
// ============================================================================
// Module      : edge_detect_3x3
// Description : 3x3 Sobel/Prewitt gradient edge detector with per-frame
//               config shadowing, binary edge map and saturated magnitude.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module edge_detect_3x3 import edge_pkg::*; #(
  parameter int DATA_WIDTH    = 8,
  parameter int IMG_WIDTH     = 640,
  parameter int CNT_WIDTH     = 12,
  parameter int DEF_THRESHOLD = 128,
  parameter int DEF_KERNEL    = 0
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_hsync,
  input  logic                  in_vsync,
  input  logic [DATA_WIDTH+2:0] cfg_threshold,
  input  logic                  cfg_kernel,
  input  logic                  cfg_invert,
  input  logic [1:0]            cfg_mag_shift,
  output logic                  edge_bin,
  output logic [DATA_WIDTH-1:0] edge_mag,
  output logic                  out_valid,
  output logic                  out_hsync,
  output logic                  out_vsync,
  output logic                  line_len_err
);

  localparam int                 c_grad_w  = grad_w(DATA_WIDTH);
  localparam int                 c_sum_w   = sum_w(DATA_WIDTH);
  localparam logic [c_sum_w-1:0] c_mag_max = c_sum_w'((1 << DATA_WIDTH) - 1);
  localparam logic [c_sum_w-1:0] c_def_thr = c_sum_w'(DEF_THRESHOLD);
  localparam kernel_e            c_def_krn = (DEF_KERNEL != 0) ? KERNEL_PREWITT : KERNEL_SOBEL;

  logic                       w_frame_start;
  logic [8:0][DATA_WIDTH-1:0] w_win;
  logic                       w_win_mask;

  logic [c_sum_w-1:0]   r_thr;
  kernel_e              r_kernel;
  logic                 r_invert;
  logic [1:0]           r_shift;
  logic [PIPE_LAT-1:0]  r_valid_d;
  logic [PIPE_LAT-1:0]  r_hsync_d;
  logic [PIPE_LAT-1:0]  r_vsync_d;
  logic [c_grad_w-1:0]  r_gx_pos, r_gx_neg, r_gy_pos, r_gy_neg;
  logic                 r_mask2;
  logic [c_grad_w-1:0]  r_gx_abs, r_gy_abs;
  logic                 r_mask3;
  logic                 r_edge_bin;
  logic [DATA_WIDTH-1:0] r_edge_mag;

  logic [c_grad_w-1:0]   w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
  logic [c_sum_w-1:0]    w_sum;
  logic [c_sum_w-1:0]    w_shifted;
  logic [DATA_WIDTH-1:0] w_mag;
  logic                  w_edge;

  // Zero-extend a corner tap
  function automatic logic [c_grad_w-1:0] ext(input logic [DATA_WIDTH-1:0] p);
    return {2'b00, p};
  endfunction

  // Side tap: doubled for Sobel, unit weight for Prewitt
  function automatic logic [c_grad_w-1:0] side(input logic [DATA_WIDTH-1:0] p, input kernel_e k);
    return (k == KERNEL_SOBEL) ? {1'b0, p, 1'b0} : {2'b00, p};
  endfunction

  window_3x3 #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMG_WIDTH  (IMG_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_window (
    .clk          (clk),
    .reset_p      (reset_p),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_hsync     (in_hsync),
    .in_vsync     (in_vsync),
    .frame_start  (w_frame_start),
    .win          (w_win),
    .win_mask     (w_win_mask),
    .line_len_err (line_len_err)
  );

  // Config is taken only at a frame start so a frame is processed uniformly
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_thr    <= c_def_thr;
      r_kernel <= c_def_krn;
      r_invert <= 1'b0;
      r_shift  <= 2'd0;
    end else if (w_frame_start) begin
      r_thr    <= cfg_threshold;
      r_kernel <= kernel_e'(cfg_kernel);
      r_invert <= cfg_invert;
      r_shift  <= cfg_mag_shift;
    end
  end

  // Control sideband delayed by the pipeline depth, independent of data
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_valid_d <= '0;
      r_hsync_d <= '0;
      r_vsync_d <= '0;
    end else begin
      r_valid_d <= {r_valid_d[PIPE_LAT-2:0], in_valid};
      r_hsync_d <= {r_hsync_d[PIPE_LAT-2:0], in_hsync};
      r_vsync_d <= {r_vsync_d[PIPE_LAT-2:0], in_vsync};
    end
  end

  // Window index = row*3 + col, row 0 oldest line, col 2 newest pixel
  assign w_gx_pos = ext(w_win[2]) + side(w_win[5], r_kernel) + ext(w_win[8]);
  assign w_gx_neg = ext(w_win[0]) + side(w_win[3], r_kernel) + ext(w_win[6]);
  assign w_gy_pos = ext(w_win[6]) + side(w_win[7], r_kernel) + ext(w_win[8]);
  assign w_gy_neg = ext(w_win[0]) + side(w_win[1], r_kernel) + ext(w_win[2]);

  // Stage 2: per-axis positive and negative partial sums
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_gx_pos <= '0;
      r_gx_neg <= '0;
      r_gy_pos <= '0;
      r_gy_neg <= '0;
      r_mask2  <= 1'b0;
    end else if (r_valid_d[0]) begin
      r_gx_pos <= w_gx_pos;
      r_gx_neg <= w_gx_neg;
      r_gy_pos <= w_gy_pos;
      r_gy_neg <= w_gy_neg;
      r_mask2  <= w_win_mask;
    end
  end

  // Stage 3: absolute gradients without signed arithmetic
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_gx_abs <= '0;
      r_gy_abs <= '0;
      r_mask3  <= 1'b0;
    end else if (r_valid_d[1]) begin
      r_gx_abs <= (r_gx_pos >= r_gx_neg) ? (r_gx_pos - r_gx_neg) : (r_gx_neg - r_gx_pos);
      r_gy_abs <= (r_gy_pos >= r_gy_neg) ? (r_gy_pos - r_gy_neg) : (r_gy_neg - r_gy_pos);
      r_mask3  <= r_mask2;
    end
  end

  assign w_sum     = {1'b0, r_gx_abs} + {1'b0, r_gy_abs};
  assign w_shifted = w_sum >> r_shift;
  assign w_mag     = (w_shifted > c_mag_max) ? {DATA_WIDTH{1'b1}} : w_shifted[DATA_WIDTH-1:0];
  assign w_edge    = (w_sum > r_thr) && r_mask3;

  // Stage 4: threshold, polarity, shift and saturate
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_edge_bin <= 1'b0;
      r_edge_mag <= '0;
    end else if (r_valid_d[2]) begin
      r_edge_bin <= w_edge ^ ~r_invert;
      r_edge_mag <= r_mask3 ? w_mag : '0;
    end
  end

  assign edge_bin  = r_edge_bin;
  assign edge_mag  = r_edge_mag;
  assign out_valid = r_valid_d[PIPE_LAT-1];
  assign out_hsync = r_hsync_d[PIPE_LAT-1];
  assign out_vsync = r_vsync_d[PIPE_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_edge_detect_3x3.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_detect_3x3
// Description : Self-checking bench for edge_detect_3x3 with a golden
//               convolution model feeding an output scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_detect_3x3;

  localparam int DW = 8;
  localparam int IW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_p = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_hsync = 1'b0;
  logic          in_vsync = 1'b0;
  logic [DW+2:0] cfg_threshold = 11'd128;
  logic          cfg_kernel = 1'b0;
  logic          cfg_invert = 1'b0;
  logic [1:0]    cfg_mag_shift = 2'd0;
  logic          edge_bin;
  logic [DW-1:0] edge_mag;
  logic          out_valid, out_hsync, out_vsync, line_len_err;

  always #5 clk = ~clk;

  edge_detect_3x3 #(
    .DATA_WIDTH    (DW),
    .IMG_WIDTH     (IW),
    .CNT_WIDTH     (CW),
    .DEF_THRESHOLD (128),
    .DEF_KERNEL    (0)
  ) dut (
    .clk           (clk),
    .reset_p       (reset_p),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_hsync      (in_hsync),
    .in_vsync      (in_vsync),
    .cfg_threshold (cfg_threshold),
    .cfg_kernel    (cfg_kernel),
    .cfg_invert    (cfg_invert),
    .cfg_mag_shift (cfg_mag_shift),
    .edge_bin      (edge_bin),
    .edge_mag      (edge_mag),
    .out_valid     (out_valid),
    .out_hsync     (out_hsync),
    .out_vsync     (out_vsync),
    .line_len_err  (line_len_err)
  );

  typedef struct packed {
    logic          bin;
    logic [DW-1:0] mag;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  int   img[IW][IW];

  // Model of the per-frame shadow configuration and sticky error
  int   m_thr = 128;
  bit   m_kern = 1'b0;
  bit   m_inv = 1'b0;
  int   m_shift = 0;
  bit   m_active = 1'b0;
  bit   m_err = 1'b0;
  bit   mon_en = 1'b0;

  // Model of the 4-cycle control delay
  logic [3:0] h_v = '0, h_h = '0, h_vs = '0;
  always @(posedge clk) begin
    if (reset_p) begin
      h_v <= '0; h_h <= '0; h_vs <= '0;
    end else begin
      h_v  <= {h_v[2:0], in_valid};
      h_h  <= {h_h[2:0], in_hsync};
      h_vs <= {h_vs[2:0], in_vsync};
    end
  end

  // Output monitor: control timing every cycle, pixel values from the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      checks++;
      if ({out_valid, out_hsync, out_vsync} !== {h_v[3], h_h[3], h_vs[3]}) begin
        errors++;
        $display("FAIL ctrl_delay got v/h/vs=%b%b%b want %b%b%b",
                 out_valid, out_hsync, out_vsync, h_v[3], h_h[3], h_vs[3]);
      end
      if (h_v[3]) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow got out_valid with no expected pixel want queued entry");
        end else begin
          e = sb_q.pop_front();
          if (edge_bin !== e.bin || edge_mag !== e.mag) begin
            errors++;
            $display("FAIL pixel got bin=%b mag=%0d want bin=%b mag=%0d",
                     edge_bin, edge_mag, e.bin, e.mag);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_defaults();
    m_thr = 128; m_kern = 1'b0; m_inv = 1'b0; m_shift = 0;
    m_active = 1'b0; m_err = 1'b0;
  endtask

  // Golden model: direct signed 3x3 convolution over the stored image
  function automatic exp_t exp_px(input int r, input int c);
    exp_t e;
    int gx, gy, p, w, s, mag;
    bit mask, is_edge;
    mask = m_active && (r >= 2) && (c >= 2) && (c < IW);
    gx = 0; gy = 0;
    if (mask) begin
      w = m_kern ? 1 : 2;
      for (int dr = 0; dr < 3; dr++) begin
        for (int dc = 0; dc < 3; dc++) begin
          p = img[r-2+dr][c-2+dc];
          gx += p * ((dc == 0) ? -1 : ((dc == 2) ? 1 : 0)) * ((dr == 1) ? w : 1);
          gy += p * ((dr == 0) ? -1 : ((dr == 2) ? 1 : 0)) * ((dc == 1) ? w : 1);
        end
      end
    end
    s = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
    is_edge = mask && (s > m_thr);
    mag = mask ? (s >> m_shift) : 0;
    if (mag > 255) mag = 255;
    e.bin = is_edge ^ !m_inv;
    e.mag = DW'(mag);
    return e;
  endfunction

  // Drive one frame; optional overlength first line, mid-frame reset row,
  // mid-frame invert toggle row and random in-line valid gaps
  task automatic send_frame(input int extra, input int rst_row, input int inv_row, input bit gaps);
    in_valid = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
    repeat (6) tick();
    in_vsync = 1'b1;
    m_thr = int'(cfg_threshold); m_kern = cfg_kernel; m_inv = cfg_invert;
    m_shift = int'(cfg_mag_shift); m_active = 1'b1;
    tick();
    for (int r = 0; r < IW; r++) begin
      if (r == rst_row) begin
        reset_p = 1'b1;
        tick();
        reset_p = 1'b0;
        model_defaults();
        sb_q.delete();
        checks++;
        if ({edge_bin, edge_mag, out_valid, out_hsync, out_vsync, line_len_err} !== '0) begin
          errors++;
          $display("FAIL mid_reset_outputs got bin=%b mag=%0d v=%b h=%b vs=%b err=%b want all 0",
                   edge_bin, edge_mag, out_valid, out_hsync, out_vsync, line_len_err);
        end
        tick();
      end
      if (r == inv_row) cfg_invert = ~cfg_invert;
      in_hsync = 1'b1;
      for (int c = 0; c < IW + ((r == 0) ? extra : 0); c++) begin
        if (gaps && ($urandom_range(0, 3) == 0)) begin
          in_valid = 1'b0;
          tick();
        end
        in_valid = 1'b1;
        if (c < IW) in_data = DW'(img[r][c]);
        else        in_data = 8'hAB;
        if (c >= IW && m_active) m_err = 1'b1;
        sb_q.push_back(exp_px(r, c));
        tick();
        checks++;
        if (line_len_err !== m_err) begin
          errors++;
          $display("FAIL line_len_err row %0d col %0d got %b want %b", r, c, line_len_err, m_err);
        end
      end
      in_valid = 1'b0; in_hsync = 1'b0;
      repeat (5) tick();
    end
  endtask

  task automatic fill_step();
    for (int r = 0; r < IW; r++)
      for (int c = 0; c < IW; c++)
        img[r][c] = (c < 4) ? 0 : 255;
  endtask

  task automatic test_reset();
    reset_p = 1'b1;
    repeat (3) tick();
    checks++;
    if ({edge_bin, edge_mag, out_valid, out_hsync, out_vsync, line_len_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got bin=%b mag=%0d v=%b h=%b vs=%b err=%b want all 0",
               edge_bin, edge_mag, out_valid, out_hsync, out_vsync, line_len_err);
    end
    reset_p = 1'b0;
    model_defaults();
    mon_en = 1'b1;
  endtask

  task automatic test_flat();
    for (int r = 0; r < IW; r++)
      for (int c = 0; c < IW; c++)
        img[r][c] = 100;
    cfg_threshold = 11'd128; cfg_kernel = 1'b0; cfg_invert = 1'b0; cfg_mag_shift = 2'd0;
    send_frame(0, -1, -1, 1'b0);
  endtask

  task automatic test_step_sobel();
    fill_step();
    cfg_threshold = 11'd128; cfg_kernel = 1'b0; cfg_invert = 1'b0; cfg_mag_shift = 2'd2;
    send_frame(0, -1, -1, 1'b0);
  endtask

  task automatic test_step_prewitt();
    fill_step();
    cfg_threshold = 11'd800; cfg_kernel = 1'b1; cfg_invert = 1'b0; cfg_mag_shift = 2'd0;
    send_frame(0, -1, -1, 1'b0);
    cfg_threshold = 11'd700;
    send_frame(0, -1, -1, 1'b0);
  endtask

  task automatic test_shadow();
    fill_step();
    cfg_threshold = 11'd128; cfg_kernel = 1'b0; cfg_invert = 1'b0; cfg_mag_shift = 2'd0;
    send_frame(0, -1, 3, 1'b0);
    send_frame(0, -1, -1, 1'b0);
  endtask

  task automatic test_back_to_back_random();
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < IW; r++)
        for (int c = 0; c < IW; c++)
          img[r][c] = int'($urandom_range(0, 255));
      cfg_threshold = 11'($urandom_range(0, 1200));
      cfg_kernel    = 1'($urandom_range(0, 1));
      cfg_invert    = 1'($urandom_range(0, 1));
      cfg_mag_shift = 2'($urandom_range(0, 3));
      send_frame(0, -1, -1, (f != 0));
    end
  endtask

  task automatic test_overlength();
    fill_step();
    cfg_threshold = 11'd128; cfg_kernel = 1'b0; cfg_invert = 1'b0; cfg_mag_shift = 2'd0;
    send_frame(1, -1, -1, 1'b0);
    send_frame(0, -1, -1, 1'b0);
    checks++;
    if (line_len_err !== 1'b1) begin
      errors++;
      $display("FAIL len_err_sticky got %b want 1", line_len_err);
    end
    reset_p = 1'b1;
    tick();
    reset_p = 1'b0;
    model_defaults();
    checks++;
    if (line_len_err !== 1'b0) begin
      errors++;
      $display("FAIL len_err_reset got %b want 0", line_len_err);
    end
  endtask

  task automatic test_mid_reset();
    fill_step();
    cfg_threshold = 11'd200; cfg_kernel = 1'b0; cfg_invert = 1'b1; cfg_mag_shift = 2'd1;
    send_frame(0, 3, -1, 1'b0);
    send_frame(0, -1, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_flat();
    test_step_sobel();
    test_step_prewitt();
    test_shadow();
    test_back_to_back_random();
    test_overlength();
    test_mid_reset();
    in_valid = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
    repeat (8) tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d pending want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/edge_detect_3x3.md
Name: edge_detect_3x3

Overview:
- Parametrised successor to the team's fixed Sobel stage.
- Performs 3x3 gradient edge detection on an 8-bit (parametrisable) grey stream.
- Kernel (Sobel/Prewitt), threshold, output polarity and magnitude scaling are runtime-selectable, latched per frame.
- Sits after median filtering. Drives both a binary edge map and a saturated gradient-magnitude stream, with frame-aware border masking and line-length error detection.

Parameters:
- DATA_WIDTH, 8, grey pixel width.
- IMG_WIDTH, 640, max pixels per line; sets line-buffer depth.
- CNT_WIDTH, 12, width of column/row counters; must satisfy 2^CNT_WIDTH > IMG_WIDTH.
- DEF_THRESHOLD, 128, threshold loaded at reset.
- DEF_KERNEL, 0, kernel select loaded at reset: 0 = Sobel, 1 = Prewitt.

Ports:
- clk, in, 1, clock.
- reset_p, in, 1, synchronous active-high reset.
- in_data, in, DATA_WIDTH, grey pixel.
- in_valid, in, 1, pixel valid.
- in_hsync, in, 1, line active.
- in_vsync, in, 1, frame active.
- cfg_threshold, in, DATA_WIDTH+3, gradient threshold.
- cfg_kernel, in, 1, 0 = Sobel, 1 = Prewitt.
- cfg_invert, in, 1, 1 = edge drives 1.
- cfg_mag_shift, in, 2, right-shift applied to magnitude.
- edge_bin, out, 1, binary edge pixel.
- edge_mag, out, DATA_WIDTH, saturated magnitude.
- out_valid, out, 1, output valid.
- out_hsync, out, 1, delayed hsync.
- out_vsync, out, 1, delayed vsync.
- line_len_err, out, 1, sticky: line exceeded IMG_WIDTH.

Behaviour:
- Reset is synchronous, active-high, on clk.
- During reset: all pipeline regs, counters and outputs = 0, line_len_err = 0, config shadows = defaults (threshold DEF_THRESHOLD, kernel DEF_KERNEL, invert 0, shift 0).
- Line-buffer RAM contents are not cleared; border masking makes stale data invisible.
- Config shadowing: cfg_* are sampled into shadow regs only on the cycle in_vsync rises (0->1). Mid-frame changes have no effect until the next frame.
- Column counter: increments on in_valid while in_hsync=1, saturates at IMG_WIDTH, clears when in_hsync=0.
- Row counter: increments on each in_hsync falling edge while in_vsync=1, saturates, clears when in_vsync=0.
- Line-length error: in_valid while col == IMG_WIDTH sets line_len_err; that pixel is not written to the line buffer. line_len_err clears only on reset_p.
- Window: two-line buffer (depth IMG_WIDTH) plus 3x3 register window, right-edge aligned to the current pixel. Shifts only on in_valid with hsync&vsync high; zeroed when hsync or vsync is low.
- Border mask: a window is complete iff col >= 2 and row >= 2 at the capturing pixel; the mask bit travels with the data.
- Pipeline, fixed latency 4 cycles from in_valid sample to out_valid:
  - S1: window capture.
  - S2: positive and negative partial sums per axis. Side weight is 2 for Sobel, 1 for Prewitt.
  - S3: |Gx|, |Gy|, DATA_WIDTH+2 bits (max 1020 Sobel).
  - S4: sum = |Gx|+|Gy|, DATA_WIDTH+3 bits (max 2040), then threshold, shift and saturate.
- Stalls: pipeline advances every clock. Each stage's data reg updates only when its valid bit is set; otherwise it holds.
- Outputs:
  - edge = (sum > threshold) && mask.
  - edge_bin = edge XOR ~invert, so default polarity is edge = 0 (black), non-edge = 1.
  - edge_mag = mask ? min(sum >> shift, 2^DATA_WIDTH-1) : 0.
- Masked (incomplete-window) pixels output non-edge and magnitude 0.
- out_valid, out_hsync and out_vsync are in_valid, in_hsync and in_vsync delayed exactly 4 cycles, unconditionally.
- Reset mid-frame: stream restarts cleanly. The first frame after reset is only valid from the next in_vsync rise; before that, counters are 0 so everything is masked.

Decomposition:
- Package edge_pkg holds:
  - KERNEL_SOBEL = 0 and KERNEL_PREWITT = 1.
  - PIPE_LAT = 4.
  - Width helper constants GRAD_W = DATA_WIDTH+2 and SUM_W = DATA_WIDTH+3.
- Sub-module window_3x3 contains the line buffer, 3x3 register window, column/row counters, mask generation and line_len_err.
- Top level holds config shadowing and the arithmetic pipeline.

Test Plan:
- Flat frame: 8x8 of all 100, Sobel, threshold 128 -> every out pixel edge_bin = 1, edge_mag = 0, out_valid exactly 4 cycles after in_valid.
- Vertical step: columns 0-3 = 0, columns 4-7 = 255, Sobel, shift 2 -> at complete windows straddling the step, sum = 1020, edge_bin = 0, edge_mag = 255. Rows 0-1 and cols 0-1 masked to 1/0.
- Same step with Prewitt, threshold 800, shift 0 -> sum = 765, edge_bin = 1, edge_mag = 255 (saturated). With threshold 700 -> edge_bin = 0.
- Config shadowing: change cfg_invert 0->1 mid-frame -> no change until the next in_vsync rise, then edge pixels drive 1.
- Overlength line: IMG_WIDTH = 8, drive 9 valids in one line -> line_len_err = 1 from the 9th pixel, stays 1 across frames until reset_p.
- Mid-frame reset: assert reset_p for 1 cycle at row 3 -> next cycle all outputs 0 and shadows at defaults. On the next frame, output matches the golden model.
